spm_result_collector: RTL and testbench
=======================================

Name: spm_result_collector

Overview:
- Downstream of the signal peak monitor (spm).
- Drives spm's data_out_available and captures the min/max word pair that spm emits at the end of each interval.
- Tags each pair with an interval index, computes peak-to-peak, and buffers results in a small FIFO.
- Serialises each result as a 4-word frame onto a 16-bit valid/ready stream for the host-side transmitter.

Parameters:
DEPTH, 4, number of result entries held in the FIFO (power of 2, ≥2)
SIGNED_CMP, 1, 1 = samples are signed two's complement (compare via bit-15 inversion); 0 = unsigned

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  global run enable
clear  input  1  synchronous flush: empties FIFO, zeroes index, abandons current frame
spm_data  input  16  spm data_out
spm_data_ready  input  1  spm data_out_ready strobe; spm_data is valid when high
spm_data_available  output  1  to spm data_out_available; high = collector can accept a pair
tx_data  output  16  serialised result word
tx_valid  output  1  tx_data valid
tx_ready  input  1  downstream accepts tx_data
overflow  output  1  sticky: a pair arrived while FIFO full

Behaviour:
- Reset (and clear): FIFO empty, index=0, pair_sel=0, word_cnt=0.
  - Outputs on reset: spm_data_available=0, tx_data=0, tx_valid=0, overflow=0.
  - clear leaves overflow unchanged; only reset clears it.
- enable=0: no capture, no tx advance, all state held, spm_data_available forced 0 on next edge.
- Input side, registered:
  - spm_data_available <= enable && (count_next < DEPTH).
  - On spm_data_ready with pair_sel=0: latch min_l, pair_sel<=1.
  - On spm_data_ready with pair_sel=1: pair_sel<=0 and push {index, min_l, spm_data, p2p}.
  - index increments (wrap 0xFFFF->0) on every completed pair, including dropped ones, so gaps reveal loss.
- p2p:
  - With SIGNED_CMP=1: a=max^0x8000, b=min^0x8000; otherwise a=max, b=min.
  - p2p = (a>=b) ? a-b : 0, computed 16-bit unsigned at push time.
- Full: a push while count==DEPTH and no same-cycle pop drops the entry and sets overflow=1.
- Push and pop in the same cycle:
  - Both take effect; count unchanged.
  - A push while full is accepted if a pop occurs that cycle.
- Output FSM, states IDLE and SEND:
  - IDLE: if FIFO non-empty, load head into the output registers, tx_data=index, tx_valid=1, word_cnt=0 -> SEND.
  - Latency: a pair completing at edge t gives tx_valid=1 after edge t+1.
  - SEND: on tx_valid&&tx_ready, word_cnt++ and tx_data steps through index -> min -> max -> p2p.
  - After the p2p word is accepted: pop FIFO; if more entries remain, load the next head immediately (no bubble, tx_valid stays 1); else tx_valid=0 -> IDLE.
  - tx_data and tx_valid are held stable while tx_valid && !tx_ready.
- clear mid-frame: tx_valid=0 after the next edge, partial frame discarded, FSM -> IDLE. A half-captured pair (pair_sel=1) is discarded.
- reset takes priority over clear; clear takes priority over enable.
- spm_data_ready while spm_data_available=0 (protocol violation) is still captured, subject to full/overflow rules.

Test Plan:
1. tx_ready=1; pair min=0xFF00, max=0x0100 -> tx words 0x0000, 0xFF00, 0x0100, 0x0200; tx_valid rises one cycle after the max strobe; then tx_valid=0.
2. SIGNED_CMP=1, pairs (0x8000, 0x7FFF) and (0x0005, 0x0003) -> p2p 0xFFFF and 0x0000; with SIGNED_CMP=0, pair (0x0003, 0x8000) -> p2p 0x7FFD.
3. tx_ready=0, DEPTH=4, five pairs -> spm_data_available=0 after the 4th pair completes.
   - The 5th pair forced anyway sets overflow=1 and is not stored.
   - Release tx_ready: exactly 16 words out with indices 0,1,2,3; the next pair carries index 5.
4. Back-to-back frames with tx_ready=1 and 2 entries queued -> 8 consecutive valid words with no bubble; a push during the last word while full is accepted.
5. clear asserted after the 2nd word of a frame -> tx_valid=0 after the next edge, FIFO empty, the next pair carries index 0, overflow unchanged.
6. Preload index to 0xFFFF via 65535 pairs (or force) -> the next frame's index word is 0xFFFF and the following one is 0x0000; enable=0 mid-frame freezes tx_data/tx_valid for the whole low period.

Source files
------------

// File: rtl/spm_result_collector.sv
// Collects min/max pairs from the signal peak monitor, tags them with an interval
// index and peak-to-peak value, queues them and streams each as a 4-word frame.
module spm_result_collector #(
  parameter int DEPTH      = 4,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] spm_data,
  input  logic        spm_data_ready,
  output logic        spm_data_available,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [15:0] idx;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] p2p;
  } entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  entry_t fifo_mem [DEPTH];

  state_t        state_reg, state_next;
  logic [1:0]    word_cnt_reg, word_cnt_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]   index_reg, index_next;
  logic          pair_sel_reg, pair_sel_next;
  logic [15:0]   min_l_reg, min_l_next;
  logic          overflow_reg, overflow_next;
  logic          avail_reg, avail_next;
  logic [15:0]   tx_data_reg, tx_data_next;
  logic          tx_valid_reg, tx_valid_next;
  entry_t        out_reg, out_next;

  logic          active;
  logic          pair_done;
  logic          tx_fire;
  logic          push;
  logic          pop;
  logic          drop;
  logic [15:0]   cmp_flip;
  logic [15:0]   cmp_a;
  logic [15:0]   cmp_b;
  logic [15:0]   p2p_value;
  entry_t        head_entry;
  entry_t        next_entry;
  entry_t        new_entry;

  function automatic logic [15:0] entry_word(input entry_t e, input logic [1:0] sel);
    case (sel)
      2'd0:    return e.idx;
      2'd1:    return e.mn;
      2'd2:    return e.mx;
      default: return e.p2p;
    endcase
  endfunction

  // Signed samples compare correctly as unsigned once the sign bit is flipped.
  always_comb begin
    cmp_flip  = SIGNED_CMP ? 16'h8000 : 16'h0000;
    cmp_a     = spm_data ^ cmp_flip;
    cmp_b     = min_l_reg ^ cmp_flip;
    p2p_value = (cmp_a >= cmp_b) ? (cmp_a - cmp_b) : 16'h0000;
  end

  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign next_entry = fifo_mem[rd_ptr_inc];
  assign new_entry  = '{idx: index_reg, mn: min_l_reg, mx: spm_data, p2p: p2p_value};

  assign active    = enable && !clear;
  assign pair_done = active && spm_data_ready && pair_sel_reg;
  assign tx_fire   = active && (state_reg == SEND) && tx_valid_reg && tx_ready;
  assign pop       = tx_fire && (word_cnt_reg == 2'd3);
  // A full FIFO still takes the new pair when the head leaves in the same cycle.
  assign push      = pair_done && ((count_reg != FULL_COUNT) || pop);
  assign drop      = pair_done && !push;

  // Capture side and FIFO bookkeeping
  always_comb begin
    index_next    = index_reg;
    pair_sel_next = pair_sel_reg;
    min_l_next    = min_l_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg | drop;
    if (clear) begin
      index_next    = 16'h0000;
      pair_sel_next = 1'b0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
    end else if (enable) begin
      if (spm_data_ready) begin
        pair_sel_next = ~pair_sel_reg;
        if (!pair_sel_reg) begin
          min_l_next = spm_data;
        end else begin
          // Dropped pairs still consume an index so the host sees the gap.
          index_next = index_reg + 16'h0001;
        end
      end
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_inc;
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
    avail_next = enable && (count_next < FULL_COUNT);
  end

  // Output framing FSM
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    out_next      = out_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    if (clear) begin
      state_next    = IDLE;
      word_cnt_next = 2'd0;
      tx_valid_next = 1'b0;
    end else if (enable) begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            out_next      = head_entry;
            tx_data_next  = head_entry.idx;
            tx_valid_next = 1'b1;
            word_cnt_next = 2'd0;
            state_next    = SEND;
          end
        end
        SEND: begin
          if (tx_fire) begin
            if (word_cnt_reg == 2'd3) begin
              word_cnt_next = 2'd0;
              if (count_reg > CW'(1)) begin
                out_next     = next_entry;
                tx_data_next = next_entry.idx;
              end else begin
                tx_valid_next = 1'b0;
                state_next    = IDLE;
              end
            end else begin
              word_cnt_next = word_cnt_reg + 2'd1;
              tx_data_next  = entry_word(out_reg, word_cnt_reg + 2'd1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      word_cnt_reg <= 2'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      index_reg    <= 16'h0000;
      pair_sel_reg <= 1'b0;
      min_l_reg    <= 16'h0000;
      overflow_reg <= 1'b0;
      avail_reg    <= 1'b0;
      tx_data_reg  <= 16'h0000;
      tx_valid_reg <= 1'b0;
      out_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      index_reg    <= index_next;
      pair_sel_reg <= pair_sel_next;
      min_l_reg    <= min_l_next;
      overflow_reg <= overflow_next;
      avail_reg    <= avail_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      out_reg      <= out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_mem[wr_ptr_reg] <= new_entry;
  end

  assign spm_data_available = avail_reg;
  assign tx_data            = tx_data_reg;
  assign tx_valid           = tx_valid_reg;
  assign overflow           = overflow_reg;

endmodule

// File: tb/tb_spm_result_collector.sv
// Directed bench for spm_result_collector: a signed and an unsigned instance share
// stimulus; a negedge monitor checks every streamed word against a frame scoreboard.
module tb_spm_result_collector;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] spm_data;
  logic        spm_data_ready;
  logic        tx_ready;
  logic        spm_data_available;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        overflow;
  logic        avail_u;
  logic [15:0] tx_data_u;
  logic        tx_valid_u;
  logic        ovf_u;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] idx;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] ps;
    logic [15:0] pu;
  } ent_t;

  ent_t        q[$];
  logic [15:0] got[$];
  logic [15:0] got_u[$];
  int          wcnt;
  logic [15:0] m_index;
  logic [15:0] m_min;
  logic        m_pair_sel;
  logic        m_ovf;
  bit          mon_on = 1'b0;
  bit          force_on = 1'b0;

  spm_result_collector #(.DEPTH(DEPTH), .SIGNED_CMP(1'b1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .spm_data(spm_data), .spm_data_ready(spm_data_ready),
    .spm_data_available(spm_data_available),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow)
  );

  spm_result_collector #(.DEPTH(DEPTH), .SIGNED_CMP(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .spm_data(spm_data), .spm_data_ready(spm_data_ready),
    .spm_data_available(avail_u),
    .tx_data(tx_data_u), .tx_valid(tx_valid_u), .tx_ready(tx_ready),
    .overflow(ovf_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] p2p_of(input logic [15:0] mn, input logic [15:0] mx,
                                         input bit sgn);
    logic [15:0] a;
    logic [15:0] b;
    a = sgn ? {~mx[15], mx[14:0]} : mx;
    b = sgn ? {~mn[15], mn[14:0]} : mn;
    return (a >= b) ? 16'(a - b) : 16'h0000;
  endfunction

  function automatic logic [15:0] word_of(input ent_t e, input int w, input bit uns);
    case (w)
      0:       return e.idx;
      1:       return e.mn;
      2:       return e.mx;
      default: return uns ? e.pu : e.ps;
    endcase
  endfunction

  // Scoreboard: pairs are pushed when their max strobe is seen, popped after 4 words.
  always @(negedge clk) begin
    if (mon_on) begin
      if (tx_valid) begin
        if (q.size() == 0) chk("tx_orphan", 16'(tx_valid), 16'd0);
        else begin
          chk("tx_data", tx_data, word_of(q[0], wcnt, 1'b0));
          chk("tx_data_u", tx_data_u, word_of(q[0], wcnt, 1'b1));
        end
      end
      chk("overflow", 16'(overflow), 16'(m_ovf));
      chk("overflow_u", 16'(ovf_u), 16'(m_ovf));
    end
    if (reset) begin
      q.delete();
      wcnt = 0;
      m_index = 16'h0000;
      m_pair_sel = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (enable && !clear && tx_valid && tx_ready) begin
        got.push_back(tx_data);
        got_u.push_back(tx_data_u);
        if (q.size() > 0) begin
          wcnt++;
          if (wcnt == 4) begin
            $display("frame idx=%h min=%h max=%h p2p_s=%h p2p_u=%h",
                     q[0].idx, q[0].mn, q[0].mx, q[0].ps, q[0].pu);
            q.pop_front();
            wcnt = 0;
          end
        end
      end
      if (clear) begin
        q.delete();
        wcnt = 0;
        m_index = 16'h0000;
        m_pair_sel = 1'b0;
      end else if (enable && spm_data_ready) begin
        if (!m_pair_sel) begin
          m_min = spm_data;
          m_pair_sel = 1'b1;
        end else begin
          m_pair_sel = 1'b0;
          if (q.size() < DEPTH)
            q.push_back('{idx: m_index, mn: m_min, mx: spm_data,
                          ps: p2p_of(m_min, spm_data, 1'b1),
                          pu: p2p_of(m_min, spm_data, 1'b0)});
          else
            m_ovf = 1'b1;
          m_index = m_index + 16'h0001;
        end
      end
      if (force_on) m_index = 16'hFFFF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [15:0] mn, input logic [15:0] mx);
    spm_data = mn;
    spm_data_ready = 1'b1;
    tick();
    spm_data = mx;
    tick();
    spm_data_ready = 1'b0;
    spm_data = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] td;

    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    spm_data = 16'h0000; spm_data_ready = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_avail", 16'(spm_data_available), 16'd0);
    chk("rst_tx_data", tx_data, 16'h0000);
    chk("rst_tx_valid", 16'(tx_valid), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    mon_on = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("avail_after_rst", 16'(spm_data_available), 16'd1);

    // 1: single pair, latency and frame contents
    base = got.size();
    tick();
    send_pair(16'hFF00, 16'h0100);
    @(negedge clk);
    chk("t1_valid_t", 16'(tx_valid), 16'd0);
    @(negedge clk);
    chk("t1_valid_t1", 16'(tx_valid), 16'd1);
    chk("t1_valid_t1_u", 16'(tx_valid_u), 16'd1);
    repeat (6) tick();
    chk("t1_valid_end", 16'(tx_valid), 16'd0);
    chk("t1_nwords", 16'(got.size() - base), 16'd4);
    chk("t1_w0", got[base], 16'h0000);
    chk("t1_w1", got[base+1], 16'hFF00);
    chk("t1_w2", got[base+2], 16'h0100);
    chk("t1_w3", got[base+3], 16'h0200);

    // 2: peak-to-peak corners, signed and unsigned
    base = got.size();
    send_pair(16'h8000, 16'h7FFF);
    send_pair(16'h0005, 16'h0003);
    send_pair(16'h0003, 16'h8000);
    repeat (20) tick();
    chk("t2_nwords", 16'(got.size() - base), 16'd12);
    chk("t2_p2p_s0", got[base+3], 16'hFFFF);
    chk("t2_p2p_s1", got[base+7], 16'h0000);
    chk("t2_p2p_u2", got_u[base+11], 16'h7FFD);

    // 3: fill, overflow, drain
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_ready = 1'b0;
    tick();
    send_pair(16'h0001, 16'h0011);
    send_pair(16'h0002, 16'h0022);
    send_pair(16'h0003, 16'h0033);
    @(negedge clk);
    chk("t3_avail_3", 16'(spm_data_available), 16'd1);
    tick();
    send_pair(16'h0004, 16'h0044);
    @(negedge clk);
    chk("t3_avail_full", 16'(spm_data_available), 16'd0);
    chk("t3_avail_full_u", 16'(avail_u), 16'd0);
    tick();
    send_pair(16'h0005, 16'h0055);
    @(negedge clk);
    chk("t3_overflow", 16'(overflow), 16'd1);
    base = got.size();
    tick();
    tx_ready = 1'b1;
    repeat (22) tick();
    chk("t3_nwords", 16'(got.size() - base), 16'd16);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_idx%0d", i), got[base + 4*i], 16'(i));
    send_pair(16'h0100, 16'h0200);
    repeat (8) tick();
    chk("t3_next_idx", got[base+16], 16'h0005);

    // 4: full FIFO streams back to back; push on the pop cycle is accepted
    tx_ready = 1'b0;
    send_pair(16'h0010, 16'h0020);
    send_pair(16'h0030, 16'h0040);
    send_pair(16'h0050, 16'h0060);
    send_pair(16'h0070, 16'h0080);
    base = got.size();
    tx_ready = 1'b1;
    fork
      begin
        repeat (2) tick();
        send_pair(16'h1234, 16'h5678);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk($sformatf("t4_valid%0d", i), 16'(tx_valid), 16'd1);
        end
        @(negedge clk);
        chk("t4_valid_end", 16'(tx_valid), 16'd0);
      end
    join
    chk("t4_nwords", 16'(got.size() - base), 16'd20);
    chk("t4_last_idx", got[base+16], 16'h000A);
    chk("t4_last_max", got[base+18], 16'h5678);

    // 5: clear mid-frame
    tick();
    tx_ready = 1'b0;
    send_pair(16'hAAAA, 16'hBBBB);
    tick();
    tx_ready = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tx_ready = 1'b0;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("t5_valid_clr", 16'(tx_valid), 16'd0);
    chk("t5_ovf_kept", 16'(overflow), 16'd1);
    repeat (3) tick();
    chk("t5_empty", 16'(tx_valid), 16'd0);
    chk("t5_avail", 16'(spm_data_available), 16'd1);
    tx_ready = 1'b1;
    base = got.size();
    send_pair(16'h0001, 16'h0002);
    repeat (8) tick();
    chk("t5_idx0", got[base], 16'h0000);

    // 6: index wrap and enable freeze
    tick();
    force_on = 1'b1;
    force u_dut.index_reg = 16'hFFFF;
    force u_dut_u.index_reg = 16'hFFFF;
    tick();
    release u_dut.index_reg;
    release u_dut_u.index_reg;
    force_on = 1'b0;
    base = got.size();
    send_pair(16'h0010, 16'h0020);
    tick();
    tick();
    enable = 1'b0;
    td = tx_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_hold_data%0d", i), tx_data, td);
      chk($sformatf("t6_hold_valid%0d", i), 16'(tx_valid), 16'd1);
    end
    chk("t6_avail_off", 16'(spm_data_available), 16'd0);
    tick();
    enable = 1'b1;
    send_pair(16'h0300, 16'h0400);
    repeat (14) tick();
    chk("t6_nwords", 16'(got.size() - base), 16'd8);
    chk("t6_idx_ffff", got[base], 16'hFFFF);
    chk("t6_p2p", got[base+3], 16'h0010);
    chk("t6_idx_wrap", got[base+4], 16'h0000);
    chk("t6_valid_end", 16'(tx_valid), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
